exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/exec_decode.sv | 58 +++++
 rtl/exec_ctrl.sv | 158 +++++++++++++++
 tb/tb_exec_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the execute controller
//   Instruction opcodes, ALU opcodes, pc_sel encodings, FSM state encoding
//   and the decoded instruction class used between exec_decode and exec_ctrl.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_NEG  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] PC_SEL_INC = 2'd0;
    localparam logic [1:0] PC_SEL_RS  = 2'd1;
    localparam logic [1:0] PC_SEL_MEM = 2'd2;

    // Instruction classes: what the FSM needs to know about an opcode.
    typedef enum logic [3:0] {
        CL_NOP  = 4'd0,
        CL_J    = 4'd1,
        CL_BRZ  = 4'd2,
        CL_BRN  = 4'd3,
        CL_ALU  = 4'd4,
        CL_SVPC = 4'd5,
        CL_LD   = 4'd6,
        CL_ST   = 4'd7,
        CL_JM   = 4'd8
    } iclass_t;

    // Classes that complete (pc_we) in their EXEC cycle.
    function automatic logic ends_in_exec(iclass_t c);
        return (c == CL_NOP) || (c == CL_J) || (c == CL_BRZ) || (c == CL_BRN);
    endfunction

endpackage

// File: rtl/exec_decode.sv
// rtl/exec_decode.sv - combinational opcode decoder
//   op        : latched instruction opcode (OPW bits, OPW >= 4)
//   cls       : instruction class
//   alu_op    : ALU opcode for the EXEC cycle
//   a_sel     : ALU A source (1 = PC)
//   b_sel     : ALU B source (1 = immediate)
//   upd_flags : instruction loads flag_z/flag_n in EXEC
//   illegal   : opcode is undefined (executed as NOP)
module exec_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op,
    output iclass_t        cls,
    output logic [2:0]     alu_op,
    output logic           a_sel,
    output logic           b_sel,
    output logic           upd_flags,
    output logic           illegal
);

    logic [3:0]     op4;
    logic [OPW-1:0] op_hi;

    assign op4   = op[3:0];
    // Any set bit above the 4-bit opcode field makes the opcode undefined.
    assign op_hi = op >> 4;

    always_comb begin
        cls       = CL_NOP;
        alu_op    = ALU_PASS;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        upd_flags = 1'b0;
        illegal   = 1'b0;
        if (op_hi != '0) begin
            illegal = 1'b1;
        end else begin
            case (op4)
                OP_NOP:  cls = CL_NOP;
                OP_ST:   cls = CL_ST;
                OP_ADD:  begin cls = CL_ALU; alu_op = ALU_ADD; upd_flags = 1'b1; end
                OP_INC:  begin cls = CL_ALU; alu_op = ALU_ADD; b_sel = 1'b1; upd_flags = 1'b1; end
                OP_NEG:  begin cls = CL_ALU; alu_op = ALU_NEG; upd_flags = 1'b1; end
                OP_SUB:  begin cls = CL_ALU; alu_op = ALU_SUB; upd_flags = 1'b1; end
                OP_J:    cls = CL_J;
                OP_BRZ:  cls = CL_BRZ;
                OP_JM:   cls = CL_JM;
                OP_BRN:  cls = CL_BRN;
                OP_LD:   cls = CL_LD;
                OP_SVPC: begin cls = CL_SVPC; alu_op = ALU_ADD; a_sel = 1'b1; b_sel = 1'b1; end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - multi-cycle execute controller (IDLE/EXEC/MEM/WB)
//   clk, rst           : clock, synchronous active-high reset
//   instr_valid/op     : instruction offer from fetch; instr_ready in IDLE
//   alu_op/a_sel/b_sel : ALU controls, active in EXEC only
//   alu_z/alu_n        : ALU flags, registered on ADD/INC/NEG/SUB EXEC
//   mem_re/mem_we      : data-memory strobes (MEM)
//   reg_we/wb_sel      : register write-back (WB)
//   pc_we/pc_sel       : PC update on each instruction's final cycle
//   flag_z/flag_n      : registered flags
//   illegal            : one-cycle pulse in EXEC of an undefined opcode
module exec_ctrl
    import cpu_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    input  logic [OPW-1:0] instr_op,
    output logic           instr_ready,
    output logic [2:0]     alu_op,
    output logic           alu_a_sel,
    output logic           alu_b_sel,
    input  logic           alu_z,
    input  logic           alu_n,
    output logic           mem_re,
    output logic           mem_we,
    output logic           reg_we,
    output logic           wb_sel,
    output logic           pc_we,
    output logic [1:0]     pc_sel,
    output logic           flag_z,
    output logic           flag_n,
    output logic           illegal
);

    state_t         state, state_nxt;
    logic [OPW-1:0] op_q;

    iclass_t        dec_cls;
    logic [2:0]     dec_alu_op;
    logic           dec_a_sel;
    logic           dec_b_sel;
    logic           dec_upd_flags;
    logic           dec_illegal;

    exec_decode #(.OPW(OPW)) u_decode (
        .op        (op_q),
        .cls       (dec_cls),
        .alu_op    (dec_alu_op),
        .a_sel     (dec_a_sel),
        .b_sel     (dec_b_sel),
        .upd_flags (dec_upd_flags),
        .illegal   (dec_illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched opcode and flags. Flags only change on an arithmetic EXEC
    // cycle, so a branch in EXEC always sees the flags from before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (state == ST_IDLE && instr_valid) begin
                op_q <= instr_op;
            end
            if (state == ST_EXEC && dec_upd_flags) begin
                flag_z <= alu_z;
                flag_n <= alu_n;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (instr_valid) state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (dec_cls)
                    CL_ALU, CL_SVPC:    state_nxt = ST_WB;
                    CL_LD, CL_ST, CL_JM: state_nxt = ST_MEM;
                    default:            state_nxt = ST_IDLE;
                endcase
            end
            ST_MEM:  state_nxt = (dec_cls == CL_LD) ? ST_WB : ST_IDLE;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs. Gated by rst so an in-flight instruction emits nothing
    // during the reset cycle itself, not just after the state clears.
    always_comb begin
        instr_ready = 1'b0;
        alu_op      = ALU_PASS;
        alu_a_sel   = 1'b0;
        alu_b_sel   = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SEL_INC;
        illegal     = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: instr_ready = 1'b1;
                ST_EXEC: begin
                    alu_op    = dec_alu_op;
                    alu_a_sel = dec_a_sel;
                    alu_b_sel = dec_b_sel;
                    illegal   = dec_illegal;
                    if (ends_in_exec(dec_cls)) begin
                        pc_we = 1'b1;
                        case (dec_cls)
                            CL_J:    pc_sel = PC_SEL_RS;
                            CL_BRZ:  pc_sel = flag_z ? PC_SEL_RS : PC_SEL_INC;
                            CL_BRN:  pc_sel = flag_n ? PC_SEL_RS : PC_SEL_INC;
                            default: pc_sel = PC_SEL_INC;
                        endcase
                    end
                end
                ST_MEM: begin
                    case (dec_cls)
                        CL_LD: mem_re = 1'b1;
                        CL_JM: begin
                            mem_re = 1'b1;
                            pc_we  = 1'b1;
                            pc_sel = PC_SEL_MEM;
                        end
                        default: begin
                            mem_we = 1'b1;
                            pc_we  = 1'b1;
                        end
                    endcase
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    wb_sel = (dec_cls == CL_LD);
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - scoreboard bench for exec_ctrl
module tb_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] instr_op = 4'b0000;
    logic       instr_ready;
    logic [2:0] alu_op;
    logic       alu_a_sel, alu_b_sel;
    logic       alu_z = 1'b0, alu_n = 1'b0;
    logic       mem_re, mem_we, reg_we, wb_sel, pc_we;
    logic [1:0] pc_sel;
    logic       flag_z, flag_n, illegal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exec_ctrl #(.OPW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_op    (instr_op),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .alu_a_sel   (alu_a_sel),
        .alu_b_sel   (alu_b_sel),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed vector: {alu_op, a_sel, b_sel, mem_re, mem_we, reg_we, wb_sel,
    //                   pc_we, pc_sel, illegal, flag_z, flag_n, instr_ready}
    logic [15:0] got;
    assign got = {alu_op, alu_a_sel, alu_b_sel, mem_re, mem_we, reg_we, wb_sel,
                  pc_we, pc_sel, illegal, flag_z, flag_n, instr_ready};

    function automatic logic [15:0] pk(logic [2:0] aop, logic as, logic bs,
                                       logic re, logic we, logic rw, logic wbs,
                                       logic pw, logic [1:0] ps, logic il,
                                       logic fz, logic fn);
        return {aop, as, bs, re, we, rw, wbs, pw, ps, il, fz, fn, 1'b0};
    endfunction

    typedef struct {
        int          cyc;
        logic [15:0] v;
        string       nm;
    } ev_t;

    ev_t sb[$];

    task automatic push(input string nm, input int c, input logic [15:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: any strobe or non-idle ALU control is a DUT output event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mem_re || mem_we || reg_we || pc_we || illegal ||
                alu_op != 3'b111 || alu_a_sel || alu_b_sel) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %b at cycle %0d, expected nothing", got, cyc);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.v || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s: got %b at cycle %0d expected %b at cycle %0d",
                                 e.nm, got, cyc, e.v, e.cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic z, input logic n, output int acc);
        int w;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: instr_ready got 0 expected 1 within 20 cycles");
        end
        instr_valid = 1'b1;
        instr_op    = op;
        alu_z       = z;
        alu_n       = n;
        acc         = cyc;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op    = 4'b1101;
    endtask

    initial begin
        int a;
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", got, pk(3'b111,0,0,0,0,0,0,0,2'd0,0,0,0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {15'd0, instr_ready}, 16'd1);

        // SUB z=1 n=0, then BRZ taken
        issue(4'b0111, 1'b1, 1'b0, a);
        push("sub_exec", a+1, pk(3'b001,0,0,0,0,0,0,0,2'd0,0,0,0));
        push("sub_wb",   a+2, pk(3'b111,0,0,0,0,1,0,1,2'd0,0,1,0));
        issue(4'b1001, 1'b0, 1'b1, a);
        push("brz_taken", a+1, pk(3'b111,0,0,0,0,0,0,1,2'd1,0,1,0));

        // NEG z=0 n=1, BRZ not taken, BRN taken
        issue(4'b0110, 1'b0, 1'b1, a);
        push("neg_exec", a+1, pk(3'b010,0,0,0,0,0,0,0,2'd0,0,1,0));
        push("neg_wb",   a+2, pk(3'b111,0,0,0,0,1,0,1,2'd0,0,0,1));
        issue(4'b1001, 1'b1, 1'b0, a);
        push("brz_not_taken", a+1, pk(3'b111,0,0,0,0,0,0,1,2'd0,0,0,1));
        issue(4'b1011, 1'b1, 1'b0, a);
        push("brn_taken", a+1, pk(3'b111,0,0,0,0,0,0,1,2'd1,0,0,1));

        // LD, JM, illegal, ST, J, NOP: flags must stay 0/1 throughout
        issue(4'b1110, 1'b1, 1'b0, a);
        push("ld_mem", a+2, pk(3'b111,0,0,1,0,0,0,0,2'd0,0,0,1));
        push("ld_wb",  a+3, pk(3'b111,0,0,0,0,1,1,1,2'd0,0,0,1));
        issue(4'b1010, 1'b1, 1'b0, a);
        push("jm_mem", a+2, pk(3'b111,0,0,1,0,0,0,1,2'd2,0,0,1));
        issue(4'b1100, 1'b1, 1'b0, a);
        push("illegal_1100", a+1, pk(3'b111,0,0,0,0,0,0,1,2'd0,1,0,1));
        issue(4'b0011, 1'b1, 1'b0, a);
        push("st_mem", a+2, pk(3'b111,0,0,0,1,0,0,1,2'd0,0,0,1));
        issue(4'b1000, 1'b1, 1'b0, a);
        push("j", a+1, pk(3'b111,0,0,0,0,0,0,1,2'd1,0,0,1));
        issue(4'b0000, 1'b1, 1'b0, a);
        push("nop", a+1, pk(3'b111,0,0,0,0,0,0,1,2'd0,0,0,1));

        // ADD, INC, SVPC
        issue(4'b0100, 1'b0, 1'b0, a);
        push("add_exec", a+1, pk(3'b100,0,0,0,0,0,0,0,2'd0,0,0,1));
        push("add_wb",   a+2, pk(3'b111,0,0,0,0,1,0,1,2'd0,0,0,0));
        issue(4'b0101, 1'b0, 1'b1, a);
        push("inc_exec", a+1, pk(3'b100,0,1,0,0,0,0,0,2'd0,0,0,0));
        push("inc_wb",   a+2, pk(3'b111,0,0,0,0,1,0,1,2'd0,0,0,1));
        issue(4'b1111, 1'b1, 1'b0, a);
        push("svpc_exec", a+1, pk(3'b100,1,1,0,0,0,0,0,2'd0,0,0,1));
        push("svpc_wb",   a+2, pk(3'b111,0,0,0,0,1,0,1,2'd0,0,0,1));

        // Reset during LD's MEM state: no strobes at all from this LD
        issue(4'b1110, 1'b0, 1'b0, a);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_mem_strobes", {11'd0, mem_re, mem_we, reg_we, pc_we, illegal}, 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_held_outputs", got, pk(3'b111,0,0,0,0,0,0,0,2'd0,0,0,0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", {14'd0, instr_ready, reg_we}, 16'b10);

        // Post-reset ADD sets both flags
        issue(4'b0100, 1'b1, 1'b1, a);
        push("add2_exec", a+1, pk(3'b100,0,0,0,0,0,0,0,2'd0,0,0,0));
        push("add2_wb",   a+2, pk(3'b111,0,0,0,0,1,0,1,2'd0,0,1,1));

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
